// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and helpers for the fetch stage and its BTB
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // tag is stored right-aligned (pc shifted past index and byte offset)
  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    logic [1:0] ctr;
  } btb_entry_t;

  localparam word_t      INSTR_BYTES    = 32'd4;
  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

  function automatic word_t pc_plus4(input word_t pc);
    return pc + INSTR_BYTES;
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer with 2-bit counters
// Built into fetch_stage only when FETCH_BTB_EN is defined.
module fetch_btb import cpu_types_pkg::*; #(
  parameter int ENTRIES = 8
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  word_t lookup_pc_i,
  output logic  pred_taken_o,
  output word_t pred_target_o,
  input  logic  upd_en_i,
  input  word_t upd_pc_i,
  input  word_t upd_target_i,
  input  logic  upd_taken_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t       entries_q [ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  word_t            lk_tag;
  word_t            up_tag;
  btb_entry_t       lk_e;
  btb_entry_t       up_e;
  logic             up_hit;

  assign lk_idx = lookup_pc_i[2 +: IDX_W];
  assign up_idx = upd_pc_i[2 +: IDX_W];
  assign lk_tag = lookup_pc_i >> (IDX_W + 2);
  assign up_tag = upd_pc_i >> (IDX_W + 2);
  assign lk_e   = entries_q[lk_idx];
  assign up_e   = entries_q[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  // lookup reads the registered array, so a same-cycle update is not visible
  assign pred_taken_o  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
  assign pred_target_o = lk_e.target;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (upd_en_i) begin
      if (upd_taken_i) begin
        if (up_hit) begin
          entries_q[up_idx].ctr    <= ctr_inc(up_e.ctr);
          entries_q[up_idx].target <= upd_target_i;
        end else begin
          entries_q[up_idx] <= '{valid: 1'b1, tag: up_tag,
                                 target: upd_target_i, ctr: CTR_WEAK_TAKEN};
        end
      end else if (up_hit) begin
        entries_q[up_idx].ctr <= ctr_dec(up_e.ctr);
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, fetch FSM, IF/ID control
// Optional branch target buffer enabled by macro FETCH_BTB_EN.
module fetch_stage import cpu_types_pkg::*; #(
  parameter word_t PC_INIT     = 32'h0000_0000,
  parameter int    BTB_ENTRIES = 8
) (
  input  logic  CLK,
  input  logic  nRST,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  halt,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  bt_update,
  input  word_t bt_pc,
  input  word_t bt_target,
  input  logic  bt_taken,
  output word_t pcplus4_out,
  output word_t instr_out,
  output word_t next_pc_out,
  output logic  fetch_valid,
  output logic  flush_out
);

  if (BTB_ENTRIES < 2 || BTB_ENTRIES > 64 ||
      (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_btb_entries
    $error("BTB_ENTRIES must be a power of two in 2..64");
  end

  fetch_state_t state_q;
  word_t        pc_q;
  word_t        pc_d;
  logic         ren_q;
  logic         in_fetch;
  word_t        pc_inc;
  logic         pred_taken;
  word_t        pred_target;
  logic         unused_in;

  assign in_fetch = (state_q == FETCH);
  assign pc_inc   = pc_plus4(pc_q);

`ifdef FETCH_BTB_EN
  fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk_i         (CLK),
    .rst_n_i       (nRST),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_en_i      (bt_update),
    .upd_pc_i      (bt_pc),
    .upd_target_i  (bt_target),
    .upd_taken_i   (bt_taken)
  );
  assign unused_in = ^redirect_pc[1:0];
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_inc;
  assign unused_in   = ^{redirect_pc[1:0], bt_update, bt_pc, bt_target, bt_taken};
`endif

  assign next_pc_out = pred_taken ? pred_target : pc_inc;
  assign pcplus4_out = pc_inc;
  assign instr_out   = imemload;
  assign imemREN     = ren_q;
  assign imemaddr    = in_fetch ? pc_q : '0;

  assign fetch_valid = in_fetch && !halt && !redirect && !stall && ihit;
  // flush is forced during reset so IF/ID never holds a stale word across it
  assign flush_out   = !nRST || (in_fetch && !halt && redirect);

  always_comb begin
    pc_d = pc_q;
    if (in_fetch && !halt) begin
      if (redirect) begin
        pc_d = {redirect_pc[31:2], 2'b00};
      end else if (!stall && ihit) begin
        pc_d = next_pc_out;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RESET;
      pc_q    <= PC_INIT;
      ren_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        RESET: begin
          state_q <= FETCH;
          ren_q   <= 1'b1;
        end
        FETCH: begin
          if (halt) begin
            state_q <= HALTED;
            ren_q   <= 1'b0;
          end
        end
        HALTED: begin
          state_q <= HALTED;
          ren_q   <= 1'b0;
        end
        default: begin
          state_q <= RESET;
          ren_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
// BTB scenarios are included when FETCH_BTB_EN is defined.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int          NENT    = 8;
  localparam int          M_RESET = 0;
  localparam int          M_FETCH = 1;
  localparam int          M_HALT  = 2;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bt_update;
  logic [31:0] bt_pc;
  logic [31:0] bt_target;
  logic        bt_taken;
  logic [31:0] pcplus4_out;
  logic [31:0] instr_out;
  logic [31:0] next_pc_out;
  logic        fetch_valid;
  logic        flush_out;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_state;
  logic [31:0] m_pc;
  bit          b_valid  [NENT];
  logic [31:0] b_pc     [NENT];
  logic [31:0] b_target [NENT];
  int          b_ctr    [NENT];

  fetch_stage #(.PC_INIT(PC_INIT), .BTB_ENTRIES(NENT)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .ihit        (ihit),
    .imemload    (imemload),
    .stall       (stall),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bt_update   (bt_update),
    .bt_pc       (bt_pc),
    .bt_target   (bt_target),
    .bt_taken    (bt_taken),
    .pcplus4_out (pcplus4_out),
    .instr_out   (instr_out),
    .next_pc_out (next_pc_out),
    .fetch_valid (fetch_valid),
    .flush_out   (flush_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // BTB slot chosen by word address; two PCs alias when they share a slot
  // but differ above it
  function automatic bit btb_hit(input logic [31:0] pc);
    int i;
    i = (pc / 4) % NENT;
    return b_valid[i] && ((b_pc[i] / (4 * NENT)) == (pc / (4 * NENT)));
  endfunction

  function automatic logic [31:0] model_next_pc();
`ifdef FETCH_BTB_EN
    int i;
    i = (m_pc / 4) % NENT;
    if (btb_hit(m_pc) && b_ctr[i] >= 2) return b_target[i];
`endif
    return m_pc + 32'd4;
  endfunction

  task automatic model_btb_train();
    int i;
    bit hit;
    i   = (bt_pc / 4) % NENT;
    hit = btb_hit(bt_pc);
    if (!bt_update) return;
    if (bt_taken) begin
      if (hit) begin
        b_ctr[i]    = (b_ctr[i] < 3) ? b_ctr[i] + 1 : 3;
        b_target[i] = bt_target;
      end else begin
        b_valid[i]  = 1'b1;
        b_pc[i]     = bt_pc;
        b_target[i] = bt_target;
        b_ctr[i]    = 2;
      end
    end else if (hit) begin
      b_ctr[i] = (b_ctr[i] > 0) ? b_ctr[i] - 1 : 0;
    end
  endtask

  task automatic model_reset();
    m_state = M_RESET;
    m_pc    = PC_INIT;
    for (int i = 0; i < NENT; i++) begin
      b_valid[i] = 1'b0;
      b_ctr[i]   = 0;
    end
  endtask

  task automatic set_in(input bit h, input bit s, input bit hl, input bit r,
                        input logic [31:0] rp);
    ihit        = h;
    stall       = s;
    halt        = hl;
    redirect    = r;
    redirect_pc = rp;
    imemload    = $urandom;
  endtask

  task automatic set_bt(input bit u, input logic [31:0] p, input logic [31:0] t, input bit tk);
    bt_update = u;
    bt_pc     = p;
    bt_target = t;
    bt_taken  = tk;
  endtask

  // entered and left at a falling edge; inputs are already applied
  task automatic cycle();
    bit          fetching;
    logic [31:0] exp_np;
    #2;
    fetching = (m_state == M_FETCH);
    exp_np   = model_next_pc();
    check_eq("imemREN", imemREN, fetching);
    if (fetching) check_eq("imemaddr", imemaddr, m_pc);
    check_eq("pcplus4_out", pcplus4_out, m_pc + 32'd4);
    check_eq("next_pc_out", next_pc_out, exp_np);
    check_eq("instr_out", instr_out, imemload);
    check_eq("fetch_valid", fetch_valid, fetching && !halt && !redirect && !stall && ihit);
    check_eq("flush_out", flush_out, fetching && !halt && redirect);
    @(posedge CLK);
    if (m_state == M_RESET) m_state = M_FETCH;
    else if (m_state == M_FETCH) begin
      if (halt) m_state = M_HALT;
      else if (redirect) m_pc = redirect_pc & ~32'd3;
      else if (!stall && ihit) m_pc = exp_np;
    end
    model_btb_train();
    @(negedge CLK);
  endtask

  // reset is dropped between clock edges to exercise the asynchronous path
  task automatic apply_reset();
    #1 nRST = 1'b0;
    #1;
    check_eq("rst_imemREN", imemREN, 1'b0);
    check_eq("rst_fetch_valid", fetch_valid, 1'b0);
    check_eq("rst_flush_out", flush_out, 1'b1);
    check_eq("rst_pcplus4", pcplus4_out, PC_INIT + 32'd4);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] frozen;
    nRST = 1'b0;
    set_in(0, 0, 0, 0, 32'h0);
    set_bt(0, 32'h0, 32'h0, 0);
    model_reset();
    repeat (2) @(negedge CLK);
    apply_reset();

    // reset release, then three back-to-back hits
    cycle();
    repeat (3) begin
      set_in(1, 0, 0, 0, 32'h0);
      cycle();
    end

    // reset abandons an outstanding fetch
    apply_reset();
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    cycle();

    // wait states
    repeat (4) begin
      set_in(0, 0, 0, 0, 32'h0);
      cycle();
    end

    // redirect outranks stall and ihit, low address bits dropped
    set_in(1, 1, 0, 1, 32'h0000_0103);
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    #1 check_eq("redir_addr", imemaddr, 32'h0000_0100);
    cycle();

    // wrap-around of the PC
    set_in(0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    #1 check_eq("wrap_pcplus4", pcplus4_out, 32'h0);
    cycle();
    cycle();

`ifdef FETCH_BTB_EN
    set_in(0, 0, 0, 0, 32'h0);
    set_bt(1, 32'h40, 32'h80, 1);
    cycle();
    set_bt(0, 32'h0, 32'h0, 0);
    set_in(0, 0, 0, 1, 32'h40);
    cycle();
    set_in(0, 0, 0, 0, 32'h0);
    #1 check_eq("btb_trained", next_pc_out, 32'h80);
    set_bt(1, 32'h40, 32'h0, 0);
    cycle();
    cycle();
    set_bt(0, 32'h0, 32'h0, 0);
    #1 check_eq("btb_untrained", next_pc_out, 32'h44);
    cycle();
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 7) == 0) ? $urandom
                                       : 32'h40 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0, rp);
      set_bt($urandom_range(0, 2) == 0, 32'h40 + ($urandom_range(0, 23) << 2),
             $urandom & ~32'd3, $urandom_range(0, 2) != 0);
      if ((m_state == M_HALT && $urandom_range(0, 9) == 0) || $urandom_range(0, 149) == 0)
        apply_reset();
      else
        cycle();
    end

    // halt wins over ihit and later redirects are ignored
    apply_reset();
    set_bt(0, 32'h0, 32'h0, 0);
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    cycle();
    frozen = m_pc;
    set_in(1, 0, 1, 0, 32'h0);
    cycle();
    set_in(1, 0, 0, 1, 32'h0000_0200);
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    cycle();
    #1;
    check_eq("halt_imemREN", imemREN, 1'b0);
    check_eq("halt_pc_frozen", pcplus4_out, frozen + 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 8, the BTB entry count (power of two, 2..64); used only with BTB_EN.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports imemREN out 1 (fetch request), imemaddr out 32 (fetch address), ihit in 1 (instruction valid this cycle), imemload in 32 (instruction word).
REQ-006 SHALL have ports stall in 1 (hazard hold), halt in 1 (halt decoded downstream), redirect in 1 (resolved branch/jump correction), redirect_pc in 32 (corrected PC).
REQ-007 SHALL have ports bt_update in 1, bt_pc in 32, bt_target in 32, bt_taken in 1: resolved-branch feedback.
REQ-008 SHALL have outputs pcplus4_out 32, instr_out 32, next_pc_out 32 (predicted next PC), fetch_valid 1 (IF/ID write enable), flush_out 1 (IF/ID flush).

Function
REQ-009 SHALL use FSM states RESET, FETCH and HALTED; RESET -> FETCH on the first edge after nRST deasserts.
REQ-010 SHALL drive imemREN=1 and imemaddr=pc in FETCH only; imemREN=0 in RESET and HALTED.
REQ-011 SHALL compute pcplus4_out=pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-012 SHALL drive instr_out=imemload combinationally, giving zero-cycle latency from ihit to the IF/ID capture edge.
REQ-013 SHALL evaluate events in FETCH in priority order halt > redirect > stall > ihit.
REQ-014 SHALL, on halt: enter HALTED, hold pc, and drive fetch_valid=0 and flush_out=0. HALTED exits only by nRST; redirect, stall and ihit are ignored in HALTED.
REQ-015 SHALL, on redirect: load pc with {redirect_pc[31:2],2'b00}, drive flush_out=1 and fetch_valid=0 in that cycle, and ignore any concurrent ihit.
REQ-016 SHALL, on stall without redirect: hold pc and drive fetch_valid=0; imemREN stays 1.
REQ-017 SHALL, on ihit with no higher-priority event: drive fetch_valid=1 and load pc with next_pc_out.
REQ-018 SHALL, with ihit=0 and no other event: hold pc, drive fetch_valid=0, and keep the request asserted.
REQ-019 SHALL drive next_pc_out as pc+4, or as the BTB target when BTB_EN is defined and the BTB predicts taken.
REQ-020 SHALL drive flush_out=0 and fetch_valid=0 in every case not covered by REQ-015 and REQ-017.

Reset
REQ-021 SHALL, while nRST=0: pc=PC_INIT, state=RESET, all BTB valid bits=0, all BTB counters=2'b00, imemREN=0, fetch_valid=0, flush_out=1.
REQ-022 SHALL make reset asserted mid-fetch take effect immediately, abandoning the outstanding request with no IF/ID write.

Configuration
REQ-023 SHALL compile the branch target buffer only when macro FETCH_BTB_EN is defined.
REQ-024 SHALL, with FETCH_BTB_EN, implement a direct-mapped BTB with index pc[2+:log2(BTB_ENTRIES)], tag = the remaining upper PC bits, and per entry a valid bit, target and 2-bit saturating counter.
REQ-025 SHALL predict taken when the entry is valid, the tag matches and counter>=2.
REQ-026 SHALL update on bt_update as follows: taken with tag miss or invalid entry allocates target/tag with counter=2'b10; taken with tag hit increments the counter (saturating at 3) and rewrites the target; not-taken with tag hit decrements the counter (saturating at 0); not-taken with tag miss makes no change.
REQ-027 SHALL let a lookup in the same cycle as an update to the same index see the pre-update contents.
REQ-028 SHALL, without FETCH_BTB_EN, make next_pc_out=pc+4 and ignore the bt_* ports (ports still present).

Structure
REQ-029 SHALL place word_t (32-bit), the fetch_state_t enum and the btb_entry_t struct in shared package cpu_types_pkg.
REQ-030 SHALL implement the BTB as sub-module fetch_btb, instantiated only under FETCH_BTB_EN.

Verification
REQ-031 SHALL cover reset: PC_INIT=0, release nRST, ihit=1 for 3 cycles -> imemaddr 0,4,8 with fetch_valid=1 each cycle.
REQ-032 SHALL cover stall versus redirect: stall=1 and redirect=1 with redirect_pc=0x0000_0103 -> pc=0x0000_0100, flush_out=1, fetch_valid=0.
REQ-033 SHALL cover halt: halt=1 while ihit=1 -> HALTED, imemREN=0, pc frozen; a later redirect has no effect.
REQ-034 SHALL cover wrap-around: pc=0xFFFF_FFFC, ihit=1 -> pcplus4_out=0, next pc 0.
REQ-035 SHALL cover BTB training (FETCH_BTB_EN): bt_update taken pc=0x40 target=0x80 -> next fetch at 0x40 gives next_pc_out=0x80; two not-taken updates -> next_pc_out=0x44.
REQ-036 SHALL cover wait states: ihit=0 for 4 cycles -> imemREN=1, imemaddr constant, fetch_valid=0.
